// File: rtl/uart_pkg.sv
// Shared constants for the UART host controller: 16550 register map, LSR bit
// positions and the controller FSM state encoding.
package uart_pkg;

    localparam logic [2:0] AddrRbrThr = 3'd0;
    localparam logic [2:0] AddrIer    = 3'd1;
    localparam logic [2:0] AddrLcr    = 3'd3;
    localparam logic [2:0] AddrLsr    = 3'd5;
    localparam logic [2:0] AddrScr    = 3'd7;

    localparam int unsigned LsrDr   = 0;
    localparam int unsigned LsrOe   = 1;
    localparam int unsigned LsrPe   = 2;
    localparam int unsigned LsrFe   = 3;
    localparam int unsigned LsrBi   = 4;
    localparam int unsigned LsrThre = 5;

    localparam logic [7:0] IerVal = 8'h03;

    typedef enum logic [3:0] {
        StInitLcrDlab,
        StInitDll,
        StInitDlm,
        StInitLcr,
        StInitIer,
        StPoll,
        StEval,
        StWrThr,
        StRdRbr,
        StGap
    } state_e;

endpackage

// File: rtl/uart_host_ctrl_if.sv
// Host byte streams plus the UART register bus, bundled for uart_host_ctrl.
// master = controller side, slave = host/UART side.
interface uart_host_ctrl_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       cs;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq;

    modport master (
        input  tx_data, tx_valid, rx_ready, rdata, irq,
        output tx_ready, rx_data, rx_valid, cs, wr, addr, wdata
    );

    modport slave (
        output tx_data, tx_valid, rx_ready, rdata, irq,
        input  tx_ready, rx_data, rx_valid, cs, wr, addr, wdata
    );

endinterface

// File: rtl/uart_host_ctrl.sv
// Configures a 16550-style UART after reset, then polls LSR to move bytes.
// Define UART_HOST_IRQ_EN to add the IER write and gate polling on irq/tx_valid.
module uart_host_ctrl
    import uart_pkg::*;
#(
    parameter logic [15:0] DIVISOR = 16'h028B,
    parameter logic [7:0]  LCR_VAL = 8'h03
) (
    input  logic             clk,
    input  logic             rst,
    uart_host_ctrl_if.master bus,
    output logic             init_done,
    output logic [3:0]       line_err
);

    state_e     state_q, state_d;
    state_e     ret_q, ret_d;
    logic       lsr_dr_q, lsr_thre_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       init_done_q;
    logic [3:0] line_err_q;
    logic       poll_ok;

    logic       cs, wr, tx_ready;
    logic [2:0] addr;
    logic [7:0] wdata;

`ifdef UART_HOST_IRQ_EN
    localparam state_e AfterLcr = StInitIer;
    assign poll_ok = bus.irq | bus.tx_valid;
`else
    localparam state_e AfterLcr = StPoll;
    logic unused_irq;
    assign unused_irq = bus.irq;
    assign poll_ok    = 1'b1;
`endif

    // Every strobe is followed by StGap; ret holds where to go afterwards.
    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        cs       = 1'b0;
        wr       = 1'b0;
        addr     = 3'd0;
        wdata    = 8'h00;
        tx_ready = 1'b0;
        unique case (state_q)
            StInitLcrDlab: begin
                cs = 1'b1; wr = 1'b1; addr = AddrLcr; wdata = LCR_VAL | 8'h80;
                state_d = StGap; ret_d = StInitDll;
            end
            StInitDll: begin
                cs = 1'b1; wr = 1'b1; addr = AddrRbrThr; wdata = DIVISOR[7:0];
                state_d = StGap; ret_d = StInitDlm;
            end
            StInitDlm: begin
                cs = 1'b1; wr = 1'b1; addr = AddrIer; wdata = DIVISOR[15:8];
                state_d = StGap; ret_d = StInitLcr;
            end
            StInitLcr: begin
                cs = 1'b1; wr = 1'b1; addr = AddrLcr; wdata = LCR_VAL & 8'h7F;
                state_d = StGap; ret_d = AfterLcr;
            end
            StInitIer: begin
                cs = 1'b1; wr = 1'b1; addr = AddrIer; wdata = IerVal;
                state_d = StGap; ret_d = StPoll;
            end
            StPoll: begin
                cs = 1'b1; addr = AddrLsr;
                state_d = StEval;
            end
            // Doubles as the gap cycle after the LSR read.
            StEval: begin
                if (lsr_dr_q && !rx_valid_q) begin
                    state_d = StRdRbr;
                end else if (lsr_thre_q && bus.tx_valid) begin
                    state_d = StWrThr;
                end else if (poll_ok) begin
                    state_d = StPoll;
                end else begin
                    state_d = StGap; ret_d = StPoll;
                end
            end
            StWrThr: begin
                // A byte withdrawn since EVAL is simply not written.
                cs       = bus.tx_valid;
                wr       = bus.tx_valid;
                addr     = AddrRbrThr;
                wdata    = bus.tx_valid ? bus.tx_data : 8'h00;
                tx_ready = bus.tx_valid;
                state_d  = StGap; ret_d = StPoll;
            end
            StRdRbr: begin
                cs = 1'b1; addr = AddrRbrThr;
                state_d = StGap; ret_d = StPoll;
            end
            StGap: begin
                if (ret_q != StPoll || poll_ok) state_d = ret_q;
            end
            default: state_d = StInitLcrDlab;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StInitLcrDlab;
            ret_q       <= StInitDll;
            lsr_dr_q    <= 1'b0;
            lsr_thre_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
            line_err_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            if (state_q == StPoll) begin
                lsr_dr_q   <= bus.rdata[LsrDr];
                lsr_thre_q <= bus.rdata[LsrThre];
                line_err_q <= line_err_q | {bus.rdata[LsrBi], bus.rdata[LsrFe],
                                            bus.rdata[LsrPe], bus.rdata[LsrOe]};
            end
            if (state_q == StRdRbr) begin
                rx_data_q  <= bus.rdata;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (state_q == StGap && ret_q == StPoll) init_done_q <= 1'b1;
        end
    end

    // Outputs are forced quiet for the whole reset cycle, not just after the edge.
    assign bus.cs       = cs & ~rst;
    assign bus.wr       = wr & ~rst;
    assign bus.addr     = rst ? 3'd0 : addr;
    assign bus.wdata    = rst ? 8'h00 : wdata;
    assign bus.tx_ready = tx_ready & ~rst;
    assign bus.rx_valid = rx_valid_q & ~rst;
    assign bus.rx_data  = rst ? 8'h00 : rx_data_q;
    assign init_done    = init_done_q & ~rst;
    assign line_err     = rst ? 4'h0 : line_err_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Bench for uart_host_ctrl: register-model responder, per-cycle reference checks,
// directed scenarios, then randomized traffic. Honours UART_HOST_IRQ_EN.
module tb_uart_host_ctrl;

    localparam logic [15:0] Div = 16'h028B;
    localparam logic [7:0]  Lcr = 8'h03;
`ifdef UART_HOST_IRQ_EN
    localparam int InitEdges = 10;
`else
    localparam int InitEdges = 8;
`endif
    localparam int KNone = 0, KPoll = 1, KRbr = 2, KThr = 3, KBad = 4, KEval = 5;

    typedef struct packed {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] data;
    } acc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_done;
    logic [3:0] line_err;
    logic [7:0] lsr_val = 8'h00;
    logic [7:0] rbr_val = 8'h00;
    logic [7:0] regs [8];

    uart_host_ctrl_if bus ();

    uart_host_ctrl #(
        .DIVISOR (Div),
        .LCR_VAL (Lcr)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done),
        .line_err  (line_err)
    );

    always #5 clk = ~clk;

    assign bus.rdata = (bus.cs && !bus.wr) ?
                       (bus.addr == 3'd5 ? lsr_val :
                        bus.addr == 3'd0 ? rbr_val : regs[bus.addr]) : 8'h00;

    always @(posedge clk) if (bus.cs && bus.wr) regs[bus.addr] <= bus.wdata;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_txr = 0;
    bit   tx_acc = 0;
    acc_t log_q[$];
    acc_t init_exp [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Reference model state, advanced once per cycle by the compare process.
    logic       m_rxv, decided, prev_cs, prev_data, prev_poll_ok;
    logic [7:0] m_rxd, m_lsr, m_lcr;
    logic [3:0] m_err;
    int         pend;

    always @(negedge clk) begin
        acc_t a;
        int   kind;
        a = '{wr: bus.wr, addr: bus.addr, data: bus.wr ? bus.wdata : bus.rdata};
        kind = KNone;
        if (rst) begin
            chk("rst_cs", bus.cs, 0);
            chk("rst_wr", bus.wr, 0);
            chk("rst_addr", bus.addr, 0);
            chk("rst_wdata", bus.wdata, 0);
            chk("rst_tx_ready", bus.tx_ready, 0);
            chk("rst_rx_valid", bus.rx_valid, 0);
            chk("rst_rx_data", bus.rx_data, 0);
            chk("rst_init_done", init_done, 0);
            chk("rst_line_err", line_err, 0);
            m_rxv = 0; m_rxd = 0; m_err = 0; m_lcr = 0; m_lsr = 0;
            pend = KPoll; decided = 0; prev_cs = 0; prev_data = 0; prev_poll_ok = 0;
        end else begin
            chk("init_done", init_done, cyc >= InitEdges);
            chk("line_err", line_err, m_err);
            chk("rx_valid", bus.rx_valid, m_rxv);
            if (m_rxv) chk("rx_data", bus.rx_data, m_rxd);
            if (!bus.cs) chk("gap_wr", bus.wr, 0);
            if (prev_cs) chk("gap_after_strobe", bus.cs, 0);
            if (bus.cs) log_q.push_back(a);
            if (cyc < InitEdges) begin
                chk("init_strobe", bus.cs, (cyc % 2) == 0);
                chk("init_tx_ready", bus.tx_ready, 0);
                if (bus.cs) begin
                    chk("init_access", a, init_exp[cyc / 2]);
                    if (bus.wr && bus.addr == 3'd3) m_lcr = bus.wdata;
                end
                prev_data = 0;
            end else begin
                if (bus.cs)
                    kind = (!bus.wr && bus.addr == 3'd5) ? KPoll :
                           (!bus.wr && bus.addr == 3'd0) ? KRbr :
                           ( bus.wr && bus.addr == 3'd0) ? KThr : KBad;
                chk("tx_ready", bus.tx_ready, kind == KThr);
                if (decided && (pend == KRbr || pend == KThr)) chk("access_due", bus.cs, 1);
`ifndef UART_HOST_IRQ_EN
                if (prev_data && !prev_cs) chk("poll_continuous", bus.cs, 1);
`endif
                decided = 0;
                if (bus.cs) begin
                    chk("access_kind", kind, pend);
                    chk("lcr_dlab", m_lcr[7], 0);
                    if (kind == KRbr) chk("rbr_backpressure", m_rxv, 0);
                    if (kind == KThr) chk("thr_data", bus.wdata, bus.tx_data);
`ifdef UART_HOST_IRQ_EN
                    if (kind == KPoll) chk("poll_gated", prev_poll_ok, 1);
`endif
                    if (kind == KPoll) begin
                        m_err = m_err | bus.rdata[4:1];
                        m_lsr = bus.rdata;
                        pend  = KEval;
                    end else begin
                        pend = KPoll;
                    end
                end else if (pend == KEval) begin
                    // Receive wins over transmit; otherwise go back to polling.
                    pend = (m_lsr[0] && !m_rxv) ? KRbr :
                           (m_lsr[5] && bus.tx_valid) ? KThr : KPoll;
                    decided = 1;
                end
                if (m_rxv && bus.rx_ready) m_rxv = 0;
                if (kind == KRbr) begin m_rxv = 1; m_rxd = bus.rdata; end
                prev_data = 1;
            end
            if (bus.tx_ready) begin n_txr++; tx_acc = 1; end
            prev_cs      = bus.cs;
            prev_poll_ok = bus.irq | bus.tx_valid;
        end
    end

    task automatic apply_reset(input int n);
        @(posedge clk); #1;
        rst = 1;
        repeat (n) @(posedge clk);
        #1;
        log_q.delete();
        rst = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_ready(input string name);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            found = bus.tx_ready;
        end
        chk(name, found, 1);
        @(posedge clk); #1;
        bus.tx_valid = 0;
        tx_acc = 0;
    endtask

    task automatic drain_rx();
        lsr_val = 8'h00;
        bus.rx_ready = 1;
        cycles(4);
        bus.rx_ready = 0;
    endtask

    initial begin
        int start, cnt, rd_i, wr_i, polls;
        bit found;
        init_exp[0] = '{wr: 1'b1, addr: 3'd3, data: Lcr | 8'h80};
        init_exp[1] = '{wr: 1'b1, addr: 3'd0, data: Div[7:0]};
        init_exp[2] = '{wr: 1'b1, addr: 3'd1, data: Div[15:8]};
        init_exp[3] = '{wr: 1'b1, addr: 3'd3, data: Lcr & 8'h7F};
        init_exp[4] = '{wr: 1'b1, addr: 3'd1, data: 8'h03};
        bus.tx_data = 0; bus.tx_valid = 0; bus.rx_ready = 0; bus.irq = 0;

        // Init sequence and init_done timing.
        apply_reset(3);
        repeat (InitEdges - 1) @(posedge clk);
        @(negedge clk); chk("init_done_early", init_done, 0);
        @(posedge clk);
        @(negedge clk); chk("init_done_on_time", init_done, 1);
        cycles(12);
        chk("init_w0", log_q[0], {1'b1, 3'd3, 8'h83});
        chk("init_w1", log_q[1], {1'b1, 3'd0, 8'h8B});
        chk("init_w2", log_q[2], {1'b1, 3'd1, 8'h02});
        chk("init_w3", log_q[3], {1'b1, 3'd3, 8'h03});
`ifdef UART_HOST_IRQ_EN
        chk("init_ier", log_q[4], {1'b1, 3'd1, 8'h03});
        chk("no_poll_when_idle", log_q.size(), 5);
        bus.irq = 1;
`else
        polls = 0;
        foreach (log_q[i]) if (i >= 4 && !log_q[i].wr && log_q[i].addr == 3'd5) polls++;
        chk("polls_running", polls >= 4, 1);
`endif

        // Single THR write.
        n_txr = 0; start = log_q.size();
        lsr_val = 8'h20; bus.tx_data = 8'h55; bus.tx_valid = 1;
        wait_tx_ready("thr_accept_seen");
        cycles(10);
        chk("tx_ready_once", n_txr, 1);
        cnt = 0;
        for (int i = start; i < log_q.size(); i++)
            if (log_q[i].wr && log_q[i].addr == 3'd0) begin
                cnt++;
                chk("thr_byte", log_q[i].data, 8'h55);
            end
        chk("thr_write_count", cnt, 1);

        // Receive with backpressure.
        start = log_q.size();
        lsr_val = 8'h61; rbr_val = 8'hA5; bus.rx_ready = 0;
        cycles(30);
        @(negedge clk);
        chk("rx_valid_held", bus.rx_valid, 1);
        chk("rx_data_a5", bus.rx_data, 8'hA5);
        cnt = 0;
        for (int i = start; i < log_q.size(); i++)
            if (!log_q[i].wr && log_q[i].addr == 3'd0) cnt++;
        chk("rbr_read_once", cnt, 1);
        drain_rx();

        // Receive ordered before transmit.
        start = log_q.size();
        lsr_val = 8'h21; rbr_val = 8'h17; bus.tx_data = 8'h3C; bus.tx_valid = 1;
        wait_tx_ready("prio_thr_seen");
        rd_i = -1; wr_i = -1;
        for (int i = start; i < log_q.size(); i++) begin
            if (rd_i < 0 && !log_q[i].wr && log_q[i].addr == 3'd0) rd_i = i;
            if (wr_i < 0 && log_q[i].wr && log_q[i].addr == 3'd0) wr_i = i;
        end
        chk("rbr_before_thr", (rd_i >= 0) && (rd_i < wr_i), 1);
        chk("prio_rx_data", bus.rx_data, 8'h17);
        drain_rx();

        // Sticky line errors.
        lsr_val = 8'h0B;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = bus.cs && !bus.wr && bus.addr == 3'd5;
        end
        chk("err_poll_seen", found, 1);
        @(posedge clk); #1;
        lsr_val = 8'h00; bus.rx_ready = 1;
        cycles(20);
        @(negedge clk);
        chk("line_err_sticky", line_err, 4'b0101);
        apply_reset(1);
        @(negedge clk);
        chk("line_err_cleared", line_err, 4'h0);
        cycles(InitEdges + 4);

        // Reset during the gap that follows a THR write.
        lsr_val = 8'h20; bus.tx_data = 8'h9E; bus.tx_valid = 1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            found = bus.tx_ready;
        end
        chk("abort_thr_seen", found, 1);
        @(posedge clk); #1;
        rst = 1; bus.tx_valid = 0; tx_acc = 0;
        @(negedge clk);
        chk("abort_cs", bus.cs, 0);
        chk("abort_tx_ready", bus.tx_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("restart_cs", bus.cs, 1);
        chk("restart_addr", bus.addr, 3'd3);
        chk("restart_wdata", bus.wdata, 8'h83);
        chk("restart_init_done", init_done, 0);

        // Randomized traffic.
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            rst          = ($urandom_range(0, 599) == 0);
            lsr_val      = ($urandom & 8'h21) |
                           (($urandom_range(0, 15) == 0) ? ($urandom & 8'h1E) : 8'h00);
            rbr_val      = $urandom;
            bus.rx_ready = ($urandom_range(0, 3) != 0);
            bus.irq      = ($urandom_range(0, 3) == 0);
            if (tx_acc) begin
                tx_acc = 0;
                bus.tx_valid = 0;
            end else if (!bus.tx_valid && $urandom_range(0, 3) == 0) begin
                bus.tx_valid = 1;
                bus.tx_data  = $urandom;
            end
        end
        rst = 0;
        cycles(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_host_ctrl.md
UART_HOST_CTRL -- requirements
Module: uart_host_ctrl

Interface
REQ-001 Parameter DIVISOR, default 16'h028B, baud divisor programmed into DLL (low byte) and DLM (high byte).
REQ-002 Parameter LCR_VAL, default 8'h03, final line-control value (8N1); bit 7 is forced to 0 when written.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tx_data  input  8  byte to transmit.
REQ-006 tx_valid  input  1  tx_data valid.
REQ-007 tx_ready  output  1  byte accepted this cycle.
REQ-008 rx_data  output  8  received byte.
REQ-009 rx_valid  output  1  rx_data valid.
REQ-010 rx_ready  input  1  consumer accepts rx_data.
REQ-011 init_done  output  1  UART configured; data path live.
REQ-012 line_err  output  4  sticky {BI,FE,PE,OE} = LSR[4:1].
REQ-013 cs  output  1  UART chip select.
REQ-014 wr  output  1  1 = write, 0 = read, valid while cs=1.
REQ-015 addr  output  3  UART register address.
REQ-016 wdata  output  8  UART write data.
REQ-017 rdata  input  8  UART read data, valid during a read strobe.
REQ-018 irq  input  1  UART interrupt; used only under UART_HOST_IRQ_EN.

Function
REQ-019 Each bus access SHALL be one strobe cycle with cs=1, followed by one gap cycle with cs=0, wr=0; accesses never occur back-to-back.
REQ-020 On a read strobe, rdata SHALL be captured at the rising edge that ends the strobe cycle.
REQ-021 Init sequence SHALL be: write addr 3 = LCR_VAL|8'h80, write addr 0 = DIVISOR[7:0], write addr 1 = DIVISOR[15:8], write addr 3 = LCR_VAL&8'h7F.
REQ-022 The first init strobe SHALL occur in the first cycle after rst deasserts; init_done SHALL rise after the final gap cycle (cycle 8 without the macro, cycle 10 with it) and stay high until reset.
REQ-023 FSM states: INIT_LCR_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_IER (macro only), POLL, EVAL, WR_THR, RD_RBR, GAP.
REQ-024 POLL SHALL read LSR (addr 5); EVAL SHALL decide the next access from the captured LSR.
REQ-025 EVAL priority: if LSR[0]=1 and rx_valid=0, go to RD_RBR (addr 0 read); else if LSR[5]=1 and tx_valid=1, go to WR_THR; otherwise return to POLL.
REQ-026 Receive SHALL take priority over transmit when both are possible.
REQ-027 tx_ready SHALL be high only in the WR_THR strobe cycle; in that cycle wdata = tx_data and addr = 0.
REQ-028 If tx_valid drops before WR_THR, no write SHALL occur.
REQ-029 The RD_RBR capture SHALL load rx_data and set rx_valid on the next cycle.
REQ-030 rx_valid SHALL hold, with rx_data stable, until rx_valid&rx_ready; RBR SHALL NOT be read while rx_valid=1 (backpressure).
REQ-031 Each captured LSR SHALL be ORed into line_err[3:0] from LSR[4:1]; line_err bits clear only on reset.
REQ-032 LCR bit 7 SHALL be 0 during every data-path access.

Reset
REQ-033 In any state, rst=1 SHALL return the FSM to INIT_LCR_DLAB on the next edge, aborting any access without a completing strobe.
REQ-034 During reset: cs=0, wr=0, addr=0, wdata=0, tx_ready=0, rx_valid=0, rx_data=0, init_done=0, line_err=0; any held byte is discarded.

Configuration
REQ-035 Macro UART_HOST_IRQ_EN.
REQ-036 When defined, INIT_IER SHALL write addr 1 = 8'h03 after INIT_LCR.
REQ-037 When defined, POLL SHALL be entered only while irq=1 or tx_valid=1; otherwise the FSM waits with cs=0.
REQ-038 When undefined, the irq input SHALL be ignored, POLL repeats continuously and no IER write occurs.

Structure
REQ-039 Shared package uart_pkg SHALL hold the register address constants (RBR_THR=0, IER=1, LCR=3, LSR=5, SCR=7), the LSR bit indices and the FSM state enum.
REQ-040 The block is a single module; no sub-module.

Verification
REQ-041 Reset release with a register-model responder -> writes (3,8'h83), (0,8'h8B), (1,8'h02), (3,8'h03) in order; init_done=1 at cycle 8.
REQ-042 LSR=8'h20 and tx_data=8'h55 with tx_valid -> one THR write of 8'h55 with tx_ready high for exactly one cycle.
REQ-043 LSR=8'h61 and RBR=8'hA5 -> rx_valid=1 with rx_data=8'hA5; with rx_ready=0, no further addr-0 reads occur.
REQ-044 LSR=8'h21 with tx_valid=1 and rx_valid=0 -> the RBR read is issued before the THR write.
REQ-045 LSR=8'h0B once -> line_err=4'b0101 persists through later clean polls; rst clears it.
REQ-046 rst asserted during a WR_THR gap cycle -> outputs at reset values next cycle and the init sequence restarts; rerun with UART_HOST_IRQ_EN -> IER write of 8'h03 seen and no polling while irq=0, tx_valid=0.
